irda_tx_arbiter: RTL and testbench

Shares the single IrDA transmitter (IR_TRANSMITTER) among NUM_REQ on-chip requesters, for example the CPU IO-bus interface and a DMA/test-pattern source. It arbitrates round-robin, latches the winner's 32-bit frame, issues the one-cycle start strobe, and tracks the transmitter busy handshake. It enforces a minimum inter-frame gap and returns a per-requester acknowledge or error. It sits between the requesters and the transmitter's iDATA / iTXD_READY / oTXD_BUSY pins, in the iCLK_50 domain.

---
 rtl/irda_tx_arbiter_if.sv | 26 ++
 rtl/irda_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_irda_tx_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/irda_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around the IrDA
// transmit arbiter. The arbiter connects through the slave modport; whoever
// drives requests and models the transmitter uses the master modport.
interface irda_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    iREQ;
  logic [32*NUM_REQ-1:0] iDATA;
  logic [NUM_REQ-1:0]    oGRANT;
  logic [NUM_REQ-1:0]    oACK;
  logic [NUM_REQ-1:0]    oERR;
  logic [31:0]           oTXD_DATA;
  logic                  oTXD_READY;
  logic                  iTXD_BUSY;
  logic                  oBUSY;

  modport master (
    output iREQ, iDATA, iTXD_BUSY,
    input  oGRANT, oACK, oERR, oTXD_DATA, oTXD_READY, oBUSY
  );

  modport slave (
    input  iREQ, iDATA, iTXD_BUSY,
    output oGRANT, oACK, oERR, oTXD_DATA, oTXD_READY, oBUSY
  );
endinterface

// File: rtl/irda_tx_arbiter.sv
// Round-robin arbiter sharing one IrDA transmitter among NUM_REQ requesters.
// Latches the winning frame word, strobes the transmitter once, follows its
// busy handshake, reports ack/err to the owner and enforces an idle gap.
module irda_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 1000,
  parameter int START_TIMEOUT = 16
) (
  input logic              iCLK,
  input logic              iRST_n,
  irda_tx_arbiter_if.slave bus
);
  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW       = $clog2(START_TIMEOUT + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_END      = GW'(GAP_LAST);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arbState_t;

  arbState_t          stateReg;
  arbState_t          stateNext;
  logic [IW-1:0]      ownerReg;
  logic [IW-1:0]      ptrReg;
  logic [31:0]        txdDataReg;
  logic [TW-1:0]      timeoutCntReg;
  logic [GW-1:0]      gapCntReg;

  logic               winnerFound;
  logic [IW-1:0]      winnerIdx;
  logic               grantNow;
  logic               ackNow;
  logic               errNow;
  logic               inFrame;
  logic [NUM_REQ-1:0] ownerOneHot;
  logic [31:0]        dataWord [NUM_REQ];

  // View the flat data bus as one word per requester, and decode the owner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gPerReq
    assign dataWord[gi]    = bus.iDATA[32*gi +: 32];
    assign ownerOneHot[gi] = (ownerReg == IW'(gi));
  end

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int candSum;
    logic [IW-1:0] candIdx;
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candSum     = 0;
    candIdx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      candSum = int'(ptrReg) + i;
      if (candSum >= NUM_REQ) begin
        candSum = candSum - NUM_REQ;
      end
      candIdx = IW'(candSum);
      if (!winnerFound && bus.iREQ[candIdx]) begin
        winnerFound = 1'b1;
        winnerIdx   = candIdx;
      end
    end
  end

  // Next-state logic plus the grant/ack/err decisions of the current cycle.
  always_comb begin
    stateNext = stateReg;
    grantNow  = 1'b0;
    ackNow    = 1'b0;
    errNow    = 1'b0;
    case (stateReg)
      IDLE: begin
        // A stale busy level from the transmitter is deliberately ignored here.
        if (winnerFound) begin
          grantNow  = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        stateNext = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.iTXD_BUSY) begin
          stateNext = WAIT_DONE;
        end else if (timeoutCntReg == TIMEOUT_LAST) begin
          errNow    = 1'b1;
          stateNext = GAP;
        end
      end
      WAIT_DONE: begin
        // Frame length belongs to the transmitter, so no timeout here.
        if (!bus.iTXD_BUSY) begin
          ackNow    = 1'b1;
          stateNext = GAP;
        end
      end
      GAP: begin
        if (gapCntReg == GAP_END) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Owner, round-robin pointer and frame word change only on a grant.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ownerReg   <= '0;
      ptrReg     <= '0;
      txdDataReg <= '0;
    end else if (grantNow) begin
      ownerReg   <= winnerIdx;
      ptrReg     <= (winnerIdx == LAST_IDX) ? '0 : winnerIdx + IW'(1);
      txdDataReg <= dataWord[winnerIdx];
    end
  end

  // Start-timeout counter: cleared by the strobe, counts while busy stays low.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      timeoutCntReg <= '0;
    end else if (stateReg == START) begin
      timeoutCntReg <= '0;
    end else if (stateReg == WAIT_BUSY && !bus.iTXD_BUSY) begin
      timeoutCntReg <= timeoutCntReg + TW'(1);
    end
  end

  // Inter-frame gap counter: zero outside GAP, counts each GAP cycle.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      gapCntReg <= '0;
    end else if (stateReg == GAP) begin
      gapCntReg <= gapCntReg + GW'(1);
    end else begin
      gapCntReg <= '0;
    end
  end

  assign inFrame        = (stateReg == START) || (stateReg == WAIT_BUSY) ||
                          (stateReg == WAIT_DONE);
  assign bus.oGRANT     = inFrame ? ownerOneHot : '0;
  assign bus.oACK       = ackNow ? ownerOneHot : '0;
  assign bus.oERR       = errNow ? ownerOneHot : '0;
  assign bus.oTXD_READY = (stateReg == START);
  assign bus.oTXD_DATA  = txdDataReg;
  assign bus.oBUSY      = (stateReg != IDLE);
endmodule

// File: tb/tb_irda_tx_arbiter.sv
// Directed bench for irda_tx_arbiter: one instance with the default 1000-cycle
// gap and one built with no gap, both driven from the same clock and reset.
module tb_irda_tx_arbiter;
  logic iCLK = 1'b0;
  logic iRST_n;
  int   total = 0;
  int   bad   = 0;

  irda_tx_arbiter_if #(.NUM_REQ(4)) ifA ();
  irda_tx_arbiter_if #(.NUM_REQ(4)) ifB ();

  irda_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(1000), .START_TIMEOUT(16)) dutA (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .bus   (ifA.slave)
  );

  irda_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .START_TIMEOUT(16)) dutB (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .bus   (ifB.slave)
  );

  always #10 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic doReset();
    iRST_n         = 1'b0;
    ifA.iREQ       = '0;
    ifA.iTXD_BUSY  = 1'b0;
    ifB.iREQ       = '0;
    ifB.iTXD_BUSY  = 1'b0;
    repeat (2) tick();
    iRST_n = 1'b1;
    tick();
  endtask

  // Ticks until dutA strobes; n is the number of clocks waited.
  task automatic waitStrobeA(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifA.oTXD_READY && n < 3000);
    chk("strobe_seen", ifA.oTXD_READY, 1'b1);
  endtask

  // Called in the strobe cycle: busy rises dly clocks later, stays len clocks.
  task automatic runFrameA(input int dly, input int len, output logic [3:0] ackSeen,
                           output logic [3:0] errSeen, output int extraReady);
    extraReady = 0;
    for (int k = 0; k < dly; k++) begin
      tick();
      if (ifA.oTXD_READY) extraReady++;
    end
    ifA.iTXD_BUSY = 1'b1;
    for (int k = 0; k < len; k++) begin
      tick();
      if (ifA.oTXD_READY) extraReady++;
    end
    ifA.iTXD_BUSY = 1'b0;
    #1;
    ackSeen = ifA.oACK;
    errSeen = ifA.oERR;
  endtask

  logic [3:0]  expGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] expWord  [5] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                32'h1000_0003, 32'h1000_0000};

  initial begin
    logic [3:0] a;
    logic [3:0] e;
    int n;
    int x;
    int cnt;

    iRST_n        = 1'b0;
    ifA.iREQ      = '0;
    ifA.iDATA     = '0;
    ifA.iTXD_BUSY = 1'b0;
    ifB.iREQ      = '0;
    ifB.iDATA     = '0;
    ifB.iTXD_BUSY = 1'b0;
    #5;
    chk("rst_grant", ifA.oGRANT, 4'b0000);
    chk("rst_busy",  ifA.oBUSY, 1'b0);
    chk("rst_ready", ifA.oTXD_READY, 1'b0);
    chk("rst_data",  ifA.oTXD_DATA, 32'h0);
    chk("rst_ackerr", {ifA.oACK, ifA.oERR}, 8'h00);
    doReset();

    // Single request, busy 2 clocks after strobe for 100 clocks, then the gap.
    ifA.iDATA[31:0] = 32'hA55A_00FF;
    ifA.iREQ        = 4'b0001;
    waitStrobeA(n);
    chk("t1_latency", n, 1);
    chk("t1_grant", ifA.oGRANT, 4'b0001);
    chk("t1_data", ifA.oTXD_DATA, 32'hA55A_00FF);
    chk("t1_obusy", ifA.oBUSY, 1'b1);
    runFrameA(2, 100, a, e, x);
    chk("t1_ack", a, 4'b0001);
    chk("t1_err", e, 4'b0000);
    chk("t1_single_strobe", x, 0);
    waitStrobeA(n);
    chk("t1_gap_to_strobe", n, 1002);

    // All four requesting from reset: order 0,1,2,3,0.
    doReset();
    for (int k = 0; k < 4; k++) ifA.iDATA[32*k +: 32] = 32'h1000_0000 + k;
    ifA.iREQ = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      waitStrobeA(n);
      chk("t2_grant", ifA.oGRANT, expGrant[f]);
      chk("t2_data", ifA.oTXD_DATA, expWord[f]);
      runFrameA(2, 5, a, e, x);
      chk("t2_ack", a, expGrant[f]);
      chk("t2_err", e, 4'b0000);
    end

    // Busy never rises: error exactly 16 clocks after the strobe.
    doReset();
    ifA.iREQ = 4'b0100;
    waitStrobeA(n);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("t3_err_early", ifA.oERR, 4'b0000);
      if (k == 16) begin
        chk("t3_err", ifA.oERR, 4'b0100);
        chk("t3_no_ack", ifA.oACK, 4'b0000);
      end
    end
    ifA.iREQ = 4'b0000;
    tick();
    chk("t3_gap_grant", ifA.oGRANT, 4'b0000);
    chk("t3_gap_obusy", ifA.oBUSY, 1'b1);

    // Requester 2 changes data and drops its request mid-frame.
    doReset();
    ifA.iDATA[95:64] = 32'hCAFE_0002;
    ifA.iREQ         = 4'b0100;
    waitStrobeA(n);
    chk("t4_data", ifA.oTXD_DATA, 32'hCAFE_0002);
    tick();
    ifA.iDATA[95:64] = 32'hDEAD_BEEF;
    ifA.iREQ         = 4'b0000;
    tick();
    ifA.iTXD_BUSY = 1'b1;
    repeat (20) tick();
    chk("t4_data_held", ifA.oTXD_DATA, 32'hCAFE_0002);
    chk("t4_grant_held", ifA.oGRANT, 4'b0100);
    ifA.iTXD_BUSY = 1'b0;
    #1;
    chk("t4_ack", ifA.oACK, 4'b0100);
    cnt = 0;
    repeat (1100) begin
      tick();
      if (ifA.oTXD_READY) cnt++;
    end
    chk("t4_no_regrant", cnt, 0);

    // Reset asserted during WAIT_DONE, then a pending request from 3.
    doReset();
    ifA.iDATA[63:32]  = 32'h0000_0011;
    ifA.iDATA[127:96] = 32'h3333_0003;
    ifA.iREQ          = 4'b0010;
    waitStrobeA(n);
    tick();
    tick();
    ifA.iTXD_BUSY = 1'b1;
    tick();
    tick();
    chk("t5_in_frame", ifA.oGRANT, 4'b0010);
    #3;
    iRST_n = 1'b0;
    #1;
    chk("t5_async_grant", ifA.oGRANT, 4'b0000);
    chk("t5_async_obusy", ifA.oBUSY, 1'b0);
    chk("t5_async_data", ifA.oTXD_DATA, 32'h0);
    chk("t5_async_ready", ifA.oTXD_READY, 1'b0);
    ifA.iTXD_BUSY = 1'b0;
    ifA.iREQ      = 4'b1000;
    tick();
    chk("t5_abort_silent", {ifA.oACK, ifA.oERR}, 8'h00);
    iRST_n = 1'b1;
    waitStrobeA(n);
    chk("t5_latency", n, 1);
    chk("t5_grant", ifA.oGRANT, 4'b1000);
    chk("t5_data", ifA.oTXD_DATA, 32'h3333_0003);

    // No-gap build: a held sole request restarts within 3 clocks of the ack.
    ifB.iDATA[31:0] = 32'h0B0B_0001;
    ifB.iREQ        = 4'b0001;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifB.oTXD_READY && n < 50);
    chk("t6_first_strobe", ifB.oTXD_READY, 1'b1);
    repeat (2) tick();
    ifB.iTXD_BUSY = 1'b1;
    repeat (3) tick();
    ifB.iTXD_BUSY = 1'b0;
    #1;
    chk("t6_ack", ifB.oACK, 4'b0001);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifB.oTXD_READY && n < 50);
    chk("t6_regrant_gap", n, 3);
    chk("t6_data", ifB.oTXD_DATA, 32'h0B0B_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
